// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit between the CPU memory stage and a word-wide
// synchronous data RAM with a 1-cycle read latency and no byte enables.
// Byte and half stores are done as read-modify-write. Byte and half loads
// are extracted from the word and then sign- or zero-extended.
// Optional feature macro: MEM_LSU_MISALIGN_TRAP_EN. When it is defined, the
// unit traps misaligned half/word accesses and adds a 'misalign' output.
module mem_lsu #(
    parameter int BIG_ENDIAN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_in,
    output logic        mem_we,
    input  logic [31:0] mem_out
`ifdef MEM_LSU_MISALIGN_TRAP_EN
    ,
    output logic        misalign
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_MRG  = 3'd2,
        S_WR   = 3'd3,
        S_EXT  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        accept_s;
    logic        we_r;
    logic [1:0]  size_r;
    logic        signed_r;
    logic [1:0]  off_r;
    logic [31:0] mem_addr_r;
    logic [31:0] merge_r;
    logic [31:0] rdata_r;

    // Bit position of the low bit of a byte lane. The lane is chosen by the byte offset.
    function automatic logic [4:0] byte_shift(input logic [1:0] off);
        logic [4:0] sh;
        if (BIG_ENDIAN != 0) begin
            sh = {~off, 3'b000};
        end else begin
            sh = {off, 3'b000};
        end
        return sh;
    endfunction

    // Bit position of the low bit of a half lane. The lane is chosen by addr[1].
    function automatic logic [4:0] half_shift(input logic hoff);
        logic [4:0] sh;
        if (BIG_ENDIAN != 0) begin
            sh = {~hoff, 4'b0000};
        end else begin
            sh = {hoff, 4'b0000};
        end
        return sh;
    endfunction

    // Pick the addressed lane out of a RAM word and extend it to 32 bits.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] off, input logic sgn);
        logic [31:0] result;
        logic [7:0]  lane8;
        logic [15:0] lane16;
        lane8  = word[byte_shift(off) +: 8];
        lane16 = word[half_shift(off[1]) +: 16];
        case (size)
            2'd0:    result = {{24{sgn & lane8[7]}}, lane8};
            2'd1:    result = {{16{sgn & lane16[15]}}, lane16};
            default: result = word;
        endcase
        return result;
    endfunction

    // Put the right-aligned store data into its lane of the old RAM word.
    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wdata,
                                                input logic [1:0] size, input logic [1:0] off);
        logic [31:0] mask;
        logic [31:0] lane_data;
        case (size)
            2'd0: begin
                mask      = 32'h0000_00FF << byte_shift(off);
                lane_data = wdata << byte_shift(off);
            end
            2'd1: begin
                mask      = 32'h0000_FFFF << half_shift(off[1]);
                lane_data = wdata << half_shift(off[1]);
            end
            default: begin
                mask      = 32'hFFFF_FFFF;
                lane_data = wdata;
            end
        endcase
        return (old & ~mask) | (lane_data & mask);
    endfunction

    assign req_ready  = (state_r == S_IDLE) && rst;
    assign accept_s   = req_valid && req_ready;
    assign mem_we     = (state_r == S_WR) && rst;
    assign mem_in     = mem_we ? merge_r : 32'h0000_0000;
    assign mem_addr   = mem_addr_r;
    assign resp_valid = (state_r == S_DONE) && rst;
    assign resp_rdata = rst ? rdata_r : 32'h0000_0000;

`ifdef MEM_LSU_MISALIGN_TRAP_EN
    logic misalign_s;
    logic misalign_r;

    assign misalign_s = ((req_size == 2'd1) && req_addr[0]) ||
                        (req_size[1] && (req_addr[1:0] != 2'b00));
    assign misalign   = resp_valid && misalign_r;

    // Remember whether the accepted request trapped, so DONE can flag it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            misalign_r <= 1'b0;
        end else if (accept_s) begin
            misalign_r <= misalign_s;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic. Word stores skip the read. Sub-word stores read, then merge, then write.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
`ifdef MEM_LSU_MISALIGN_TRAP_EN
                    if (misalign_s) begin
                        state_nxt_s = S_DONE;
                    end else if (req_we && req_size[1]) begin
                        state_nxt_s = S_WR;
                    end else begin
                        state_nxt_s = S_RD;
                    end
`else
                    if (req_we && req_size[1]) begin
                        state_nxt_s = S_WR;
                    end else begin
                        state_nxt_s = S_RD;
                    end
`endif
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_RD: begin
                if (we_r) begin
                    state_nxt_s = S_MRG;
                end else begin
                    state_nxt_s = S_EXT;
                end
            end
            S_MRG:   state_nxt_s = S_WR;
            S_WR:    state_nxt_s = S_DONE;
            S_EXT:   state_nxt_s = S_DONE;
            S_DONE:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Request latches. The merge register first holds the store data; MRG then overwrites it with the merged word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            we_r       <= 1'b0;
            size_r     <= 2'd0;
            signed_r   <= 1'b0;
            off_r      <= 2'd0;
            mem_addr_r <= 32'h0000_0000;
            merge_r    <= 32'h0000_0000;
            rdata_r    <= 32'h0000_0000;
        end else begin
            if (accept_s) begin
                we_r       <= req_we;
                size_r     <= req_size;
                signed_r   <= req_signed;
                off_r      <= req_addr[1:0];
                mem_addr_r <= {2'b00, req_addr[31:2]};
                merge_r    <= req_wdata;
                rdata_r    <= 32'h0000_0000;
            end
            if (state_r == S_EXT) begin
                rdata_r <= load_extract(mem_out, size_r, off_r, signed_r);
            end
            if (state_r == S_MRG) begin
                merge_r <= store_merge(mem_out, merge_r, size_r, off_r);
            end
        end
    end

endmodule
